// File: rtl/hs_pkg.sv
// Shared definitions for the source-side handshake serializer: FSM encoding and default sizing.
package hs_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_NCHUNK = 4;
  localparam int unsigned DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/hs_word_fifo.sv
// Synchronous word FIFO with first-word-fall-through read data; DEPTH must be a power of 2.
module hs_word_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hs_src_serializer.sv
// Source-clock feeder for the req/ack synchronizer: buffers producer words and issues
// them one WIDTH-bit chunk per handshake, MSB chunk first, advancing only on sdone.
module hs_src_serializer
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NCHUNK = DEF_NCHUNK,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH*NCHUNK-1:0] in_data,
  output logic                    in_ready,
  input  logic                    sidle,
  input  logic                    sdone,
  output logic                    sready,
  output logic [WIDTH-1:0]        din,
  output logic                    busy,
  output logic [15:0]             xfer_cnt
);

  localparam int unsigned WW = WIDTH * NCHUNK;
  localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t         state;
  logic [WW-1:0]  shreg;
  logic [IW-1:0]  idx;

  logic           fifo_push;
  logic           fifo_pop;
  logic [WW-1:0]  fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & ~fifo_full;
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

  hs_word_fifo #(
    .W     (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sclk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pop either from idle, or straight out of S_DONE on the last chunk so words chain without an idle hop.
  always_comb begin
    fifo_pop = 1'b0;
    unique case (state)
      S_IDLE:  fifo_pop = ~fifo_empty;
      S_DONE:  fifo_pop = sdone && (idx == LAST) && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      idx      <= '0;
      sready   <= 1'b0;
      din      <= '0;
      xfer_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            idx   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sidle) begin
            sready <= 1'b1;
            din    <= shreg[WW-1 -: WIDTH];
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          sready <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (sdone) begin
            xfer_cnt <= xfer_cnt + 16'd1;
            if (idx != LAST) begin
              idx   <= idx + IW'(1);
              shreg <= shreg << WIDTH;
              state <= S_WAIT;
            end else if (!fifo_empty) begin
              shreg <= fifo_dout;
              idx   <= '0;
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
